// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the bimodal branch history table.
// Holds the branch-type encodings, the FSM state encoding and the
// branch-type classification helpers used by lookup and update paths.
package branch_predictor_bht_pkg;

  // 3-bit branch-type codes; every code not listed here is "not a branch".
  localparam logic [2:0] BT_JUMP  = 3'b100;
  localparam logic [2:0] BT_COND0 = 3'b101;
  localparam logic [2:0] BT_COND1 = 3'b110;
  localparam logic [2:0] BT_COND2 = 3'b111;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_conditional(input logic [2:0] bt);
    return (bt == BT_COND0) || (bt == BT_COND1) || (bt == BT_COND2);
  endfunction

  function automatic logic is_unconditional(input logic [2:0] bt);
    return (bt == BT_JUMP);
  endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter_update.sv
// Combinational next-value of a CTR_BITS-wide saturating counter.
// Ports:
//   ctr      - current counter value
//   taken    - 1: count up (saturate at all-ones), 0: count down (saturate at 0)
//   next_ctr - resulting counter value
module sat_counter_update #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next_ctr
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  // Saturating increment / decrement.
  always_comb begin
    next_ctr = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) begin
        next_ctr = ctr + CTR_ONE;
      end else begin
        next_ctr = ctr;
      end
    end else begin
      if (ctr != CTR_MIN) begin
        next_ctr = ctr - CTR_ONE;
      end else begin
        next_ctr = ctr;
      end
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table.
// After reset a sweep writes INIT_CTR into every entry (one per cycle);
// then the table answers fetch lookups and trains on execute updates.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   lk_valid/lk_pc/lk_branch_type       - fetch lookup request
//   predict/unconditional_jump/
//   predict_taken                       - registered lookup result (1 cycle later)
//   ready                               - high once the init sweep is done
//   up_valid/up_pc/up_branch_type/
//   up_taken/up_mispredict              - resolved-branch update from execute
//   mispredict_count                    - saturating count of conditional mispredicts
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lk_valid,
  input  logic [PC_WIDTH-1:0] lk_pc,
  input  logic [2:0]          lk_branch_type,
  output logic                predict,
  output logic                unconditional_jump,
  output logic                predict_taken,
  output logic                ready,
  input  logic                up_valid,
  input  logic [PC_WIDTH-1:0] up_pc,
  input  logic [2:0]          up_branch_type,
  input  logic                up_taken,
  input  logic                up_mispredict,
  output logic [15:0]         mispredict_count
);

  localparam int                  DEPTH      = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] INIT_VALUE = CTR_BITS'(INIT_CTR);
  localparam logic [15:0]         CNT_MAX    = 16'hFFFF;

  state_t                  state_r;
  logic [INDEX_BITS-1:0]   sweep_idx_r;
  logic [CTR_BITS-1:0]     table_r [DEPTH];

  logic                    predict_r;
  logic                    uncond_r;
  logic                    taken_r;
  logic [15:0]             mis_cnt_r;

  logic [INDEX_BITS-1:0]   lk_idx_s;
  logic [INDEX_BITS-1:0]   up_idx_s;
  logic                    up_en_s;
  logic [CTR_BITS-1:0]     up_cur_s;
  logic [CTR_BITS-1:0]     up_next_s;
  logic [CTR_BITS-1:0]     lk_ctr_s;
  logic                    predict_s;
  logic                    uncond_s;
  logic                    taken_s;
  logic                    unused_pc_bits_s;

  // Word-aligned PC slice; upper bits and pc[1:0] alias by design.
  assign lk_idx_s = lk_pc[INDEX_BITS+1:2];
  assign up_idx_s = up_pc[INDEX_BITS+1:2];
  assign unused_pc_bits_s = ^{lk_pc[PC_WIDTH-1:INDEX_BITS+2], lk_pc[1:0],
                              up_pc[PC_WIDTH-1:INDEX_BITS+2], up_pc[1:0]};

  assign up_en_s  = (state_r == ST_RUN) && up_valid && is_conditional(up_branch_type);
  assign up_cur_s = table_r[up_idx_s];

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat (
    .ctr      (up_cur_s),
    .taken    (up_taken),
    .next_ctr (up_next_s)
  );

  // Write-first bypass: a same-cycle update to the looked-up entry wins.
  always_comb begin
    lk_ctr_s = table_r[lk_idx_s];
    if (up_en_s && (up_idx_s == lk_idx_s)) begin
      lk_ctr_s = up_next_s;
    end else begin
      lk_ctr_s = table_r[lk_idx_s];
    end
  end

  // Next values of the lookup output registers.
  always_comb begin
    predict_s = 1'b0;
    uncond_s  = 1'b0;
    taken_s   = 1'b0;
    if (lk_valid) begin
      if (is_conditional(lk_branch_type)) begin
        predict_s = 1'b1;
        // Table contents are not trustworthy until the sweep has finished.
        taken_s   = (state_r == ST_RUN) ? lk_ctr_s[CTR_BITS-1] : 1'b0;
      end else if (is_unconditional(lk_branch_type)) begin
        uncond_s  = 1'b1;
        taken_s   = 1'b1;
      end else begin
        predict_s = 1'b0;
      end
    end else begin
      predict_s = 1'b0;
    end
  end

  // FSM and init sweep index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      sweep_idx_r <= {INDEX_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          if (&sweep_idx_r) begin
            state_r     <= ST_RUN;
            sweep_idx_r <= {INDEX_BITS{1'b0}};
          end else begin
            sweep_idx_r <= sweep_idx_r + {{(INDEX_BITS-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r     <= ST_INIT;
          sweep_idx_r <= {INDEX_BITS{1'b0}};
        end
      endcase
    end
  end

  // Counter table: sweep writes during INIT, training writes during RUN.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_INIT)) begin
      table_r[sweep_idx_r] <= INIT_VALUE;
    end else if (!reset && up_en_s) begin
      table_r[up_idx_s] <= up_next_s;
    end
  end

  // Registered lookup outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      predict_r <= 1'b0;
      uncond_r  <= 1'b0;
      taken_r   <= 1'b0;
    end else begin
      predict_r <= predict_s;
      uncond_r  <= uncond_s;
      taken_r   <= taken_s;
    end
  end

  // Saturating mispredict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_cnt_r <= 16'h0000;
    end else if (up_en_s && up_mispredict && (mis_cnt_r != CNT_MAX)) begin
      mis_cnt_r <= mis_cnt_r + 16'h0001;
    end
  end

  assign predict            = predict_r;
  assign unconditional_jump = uncond_r;
  assign predict_taken      = taken_r;
  assign ready              = (state_r == ST_RUN);
  assign mispredict_count   = mis_cnt_r;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic [2:0]  lk_branch_type;
  logic        predict;
  logic        unconditional_jump;
  logic        predict_taken;
  logic        ready;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [2:0]  up_branch_type;
  logic        up_taken;
  logic        up_mispredict;
  logic [15:0] mispredict_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk                (clk),
    .reset              (reset),
    .lk_valid           (lk_valid),
    .lk_pc              (lk_pc),
    .lk_branch_type     (lk_branch_type),
    .predict            (predict),
    .unconditional_jump (unconditional_jump),
    .predict_taken      (predict_taken),
    .ready              (ready),
    .up_valid           (up_valid),
    .up_pc              (up_pc),
    .up_branch_type     (up_branch_type),
    .up_taken           (up_taken),
    .up_mispredict      (up_mispredict),
    .mispredict_count   (mispredict_count)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [2:0] bt);
    lk_valid = 1'b1; lk_pc = pc; lk_branch_type = bt;
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [2:0] bt,
                        input logic tk, input logic mis);
    up_valid = 1'b1; up_pc = pc; up_branch_type = bt; up_taken = tk; up_mispredict = mis;
    tick();
    up_valid = 1'b0; up_mispredict = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic p, input logic u, input logic t);
    check_value({tag, ".predict"}, {31'd0, predict}, {31'd0, p});
    check_value({tag, ".uncond"},  {31'd0, unconditional_jump}, {31'd0, u});
    check_value({tag, ".taken"},   {31'd0, predict_taken}, {31'd0, t});
  endtask

  // Count cycles until ready rises, bounded.
  task automatic wait_ready(input string tag);
    int cycles = 0;
    while (!ready && cycles < 200) begin
      tick();
      cycles++;
    end
    check_value(tag, cycles, 32'd64);
  endtask

  initial begin
    reset = 1'b1;
    lk_valid = 1'b0; lk_pc = 32'd0; lk_branch_type = 3'b000;
    up_valid = 1'b0; up_pc = 32'd0; up_branch_type = 3'b000;
    up_taken = 1'b0; up_mispredict = 1'b0;
    tick();
    tick();
    check_value("reset.ready", {31'd0, ready}, 32'd0);
    check_value("reset.count", {16'd0, mispredict_count}, 32'd0);
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    wait_ready("init.cycles");

    // All entries weakly not-taken after the sweep.
    lookup(32'h0000_1234, 3'b101); check_outputs("run.cond_init", 1'b1, 1'b0, 1'b0);
    lookup(32'hFFFF_FFFC, 3'b111); check_outputs("run.cond_top",  1'b1, 1'b0, 1'b0);

    // Train pc 0x40 (index 16): 1 -> 2 -> 3.
    update(32'h40, 3'b101, 1'b1, 1'b0);
    update(32'h40, 3'b101, 1'b1, 1'b0);
    lookup(32'h40, 3'b101); check_outputs("train.taken", 1'b1, 1'b0, 1'b1);

    // Saturate at 3, one not-taken -> 2 (still taken).
    for (int i = 0; i < 5; i++) update(32'h40, 3'b110, 1'b1, 1'b0);
    update(32'h40, 3'b110, 1'b0, 1'b0);
    lookup(32'h40, 3'b110); check_value("sat_hi.taken", {31'd0, predict_taken}, 32'd1);
    // 2 -> 1 -> 0 -> 0.
    for (int i = 0; i < 3; i++) update(32'h40, 3'b110, 1'b0, 1'b0);
    lookup(32'h40, 3'b110); check_value("sat_lo.taken", {31'd0, predict_taken}, 32'd0);
    // From 0 one taken gives 1, still not-taken (proves floor at 0).
    update(32'h40, 3'b101, 1'b1, 1'b0);
    lookup(32'h40, 3'b101); check_value("floor.taken", {31'd0, predict_taken}, 32'd0);

    // Unconditional and non-branch decode.
    lookup(32'h44, 3'b100); check_outputs("jump", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) update(32'h44, 3'b100, 1'b1, 1'b0);
    update(32'h44, 3'b010, 1'b1, 1'b0);
    lookup(32'h44, 3'b101); check_value("jump_noupd.taken", {31'd0, predict_taken}, 32'd0);
    lookup(32'h44, 3'b011); check_outputs("nonbranch", 1'b0, 1'b0, 1'b0);
    lookup(32'h44, 3'b100);
    tick(); check_outputs("idle", 1'b0, 1'b0, 1'b0);

    // Bypass: pc 0x80 (index 32) at 1, same-cycle taken update -> 2.
    up_valid = 1'b1; up_pc = 32'h80; up_branch_type = 3'b101; up_taken = 1'b1;
    lk_valid = 1'b1; lk_pc = 32'h80; lk_branch_type = 3'b101;
    tick();
    check_value("bypass.taken", {31'd0, predict_taken}, 32'd1);
    // Different index: update 0x80 (2 -> 3), lookup 0x84 (index 33, still 1).
    lk_pc = 32'h84;
    tick();
    up_valid = 1'b0; lk_valid = 1'b0;
    check_value("nobypass.taken", {31'd0, predict_taken}, 32'd0);
    // Aliasing: upper bits and pc[1:0] ignored -> index 32 at 3.
    lookup(32'h0000_1080, 3'b101); check_value("alias_hi.taken", {31'd0, predict_taken}, 32'd1);
    lookup(32'h0000_0083, 3'b101); check_value("alias_lo.taken", {31'd0, predict_taken}, 32'd1);

    // Mispredict counting: only conditional types.
    for (int i = 0; i < 3; i++) update(32'h100, 3'b101, 1'b0, 1'b1);
    update(32'h100, 3'b100, 1'b1, 1'b1);
    update(32'h100, 3'b001, 1'b1, 1'b1);
    check_value("mis.count3", {16'd0, mispredict_count}, 32'd3);

    // Restart: reset, then interrupt the sweep at index 30.
    reset = 1'b1;
    tick();
    check_value("rst2.count", {16'd0, mispredict_count}, 32'd0);
    check_value("rst2.ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    lookup(32'h80, 3'b101); check_outputs("init.cond", 1'b1, 1'b0, 1'b0);
    update(32'h80, 3'b101, 1'b1, 1'b1);
    for (int i = 0; i < 28; i++) tick();
    check_value("init.nocount", {16'd0, mispredict_count}, 32'd0);
    check_value("init.ready30", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("restart.cycles");
    lookup(32'h80, 3'b101); check_value("reinit.taken", {31'd0, predict_taken}, 32'd0);

    // Saturation of mispredict_count.
    up_valid = 1'b1; up_pc = 32'h200; up_branch_type = 3'b110;
    up_taken = 1'b0; up_mispredict = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check_value("mis.fffe", {16'd0, mispredict_count}, 32'h0000_FFFE);
    for (int i = 0; i < 4466; i++) tick();
    up_valid = 1'b0; up_mispredict = 1'b0;
    check_value("mis.sat", {16'd0, mispredict_count}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
